// File: rtl/led_heartbeat_driver.sv
// led_heartbeat_driver
//   Turns the once-per-second sec_tick pulse into a board LED pattern
//   (off, 1 Hz blink, double-blip heartbeat, PWM breathing) and keeps a
//   wrapping count of elapsed seconds for status/debug.
//
// Ports
//   clk          system clock (single-ended copy of the LVDS clock)
//   rst_n        asynchronous active-low reset
//   sec_tick     one-cycle pulse per second, synchronous to clk
//   mode[1:0]    requested pattern: 0 OFF, 1 BLINK, 2 HEARTBEAT, 3 BREATHE
//   mode_active  pattern currently in force (changes only on sec_tick)
//   beat_cnt     seconds elapsed since reset, wraps 255 -> 0
//   led_h        LED drive
//
// Optional build macro
//   LED_ACTIVE_LOW_EN  when defined, led_h is the inverse of the pattern
//                      value (current-sinking LED); resets to 1 and OFF
//                      drives 1.
//
// Heartbeat FSM
//   state     | meaning
//   HB_IDLE   | waiting for a tick, led off
//   HB_BLIP1  | first blip, led on for BLIP_CYC cycles
//   HB_GAP    | gap between blips, led off for BLIP_CYC cycles
//   HB_BLIP2  | second blip, led on for BLIP_CYC cycles
module led_heartbeat_driver #(
    parameter int CLK_HZ   = 16368000,
    parameter int BLIP_MS  = 100,
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [1:0] mode,
    output logic [1:0] mode_active,
    output logic [7:0] beat_cnt,
    output logic       led_h
);

    localparam int BLIP_CYC = int'((64'(CLK_HZ) * 64'(BLIP_MS)) / 64'd1000);
    localparam int STEP_CYC = CLK_HZ >> PWM_BITS;
    localparam int TW       = $clog2(BLIP_CYC + 1);
    localparam int PW       = $clog2(STEP_CYC + 1);

    localparam logic [TW-1:0]       T_LAST   = TW'(BLIP_CYC - 1);
    localparam logic [PW-1:0]       P_LAST   = PW'(STEP_CYC - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_BLINK = 2'd1;
    localparam logic [1:0] M_HB    = 2'd2;
    localparam logic [1:0] M_BR    = 2'd3;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    typedef enum logic [1:0] {HB_IDLE, HB_BLIP1, HB_GAP, HB_BLIP2} hb_state_t;

    hb_state_t             hb_state, hb_state_d;
    logic [TW-1:0]         hb_timer, hb_timer_d;
    logic [PWM_BITS-1:0]   duty, duty_d;
    logic [PWM_BITS-1:0]   pwm_cnt, pwm_cnt_d;
    logic [PW-1:0]         presc, presc_d;
    logic                  dir_up, dir_up_d;
    logic [1:0]            mode_active_d;
    logic [7:0]            beat_cnt_d;
    logic                  pat_q, pat_d;
    logic                  entering;

    // The logical pattern value is recovered from the registered pin so
    // BLINK can toggle without a second copy of the LED state.
    assign pat_q = led_h ^ LED_INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_state    <= HB_IDLE;
            hb_timer    <= '0;
            duty        <= '0;
            pwm_cnt     <= '0;
            presc       <= '0;
            dir_up      <= 1'b1;
            mode_active <= M_OFF;
            beat_cnt    <= 8'd0;
            led_h       <= LED_INV;
        end else begin
            hb_state    <= hb_state_d;
            hb_timer    <= hb_timer_d;
            duty        <= duty_d;
            pwm_cnt     <= pwm_cnt_d;
            presc       <= presc_d;
            dir_up      <= dir_up_d;
            mode_active <= mode_active_d;
            beat_cnt    <= beat_cnt_d;
            led_h       <= pat_d ^ LED_INV;
        end
    end

    always_comb begin
        hb_state_d    = hb_state;
        hb_timer_d    = hb_timer;
        duty_d        = duty;
        pwm_cnt_d     = pwm_cnt + 1'b1;
        presc_d       = presc;
        dir_up_d      = dir_up;
        mode_active_d = mode_active;
        beat_cnt_d    = beat_cnt;
        pat_d         = 1'b0;
        entering      = 1'b0;

        if (sec_tick) begin
            beat_cnt_d = beat_cnt + 8'd1;
            if (mode != mode_active) begin
                mode_active_d = mode;
                entering      = 1'b1;
                hb_state_d    = HB_IDLE;
                hb_timer_d    = '0;
                duty_d        = '0;
                dir_up_d      = 1'b1;
                presc_d       = '0;
            end
        end

        case (mode_active_d)
            M_OFF: begin
                pat_d = 1'b0;
            end
            M_BLINK: begin
                if (entering)      pat_d = 1'b1;
                else if (sec_tick) pat_d = ~pat_q;
                else               pat_d = pat_q;
            end
            M_HB: begin
                if (sec_tick) begin
                    // A tick always restarts the double blip, even mid-sequence.
                    hb_state_d = HB_BLIP1;
                    hb_timer_d = '0;
                end else if (hb_state != HB_IDLE) begin
                    if (hb_timer == T_LAST) begin
                        hb_timer_d = '0;
                        case (hb_state)
                            HB_BLIP1: hb_state_d = HB_GAP;
                            HB_GAP:   hb_state_d = HB_BLIP2;
                            default:  hb_state_d = HB_IDLE;
                        endcase
                    end else begin
                        hb_timer_d = hb_timer + 1'b1;
                    end
                end
                pat_d = (hb_state_d == HB_BLIP1) || (hb_state_d == HB_BLIP2);
            end
            default: begin
                if (sec_tick) begin
                    // The mode-entry tick leaves the ramp pointing up.
                    presc_d = '0;
                    if (!entering) dir_up_d = ~dir_up;
                end else if (presc == P_LAST) begin
                    presc_d = '0;
                    if (dir_up && duty != DUTY_MAX)  duty_d = duty + 1'b1;
                    else if (!dir_up && duty != '0)  duty_d = duty - 1'b1;
                end else begin
                    presc_d = presc + 1'b1;
                end
                pat_d = (pwm_cnt_d < duty_d);
            end
        endcase
    end

endmodule

// File: tb/tb_led_heartbeat_driver.sv
module tb_led_heartbeat_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] mode_active;
    logic [7:0] beat_cnt;
    logic       led_h;

`ifdef LED_ACTIVE_LOW_EN
    localparam int INV = 1;
`else
    localparam int INV = 0;
`endif
    localparam logic ON_V  = (INV == 0);
    localparam logic OFF_V = (INV != 0);
    localparam int BLIP = 10;
    localparam int STEP = 62;
    localparam int DMAX = 15;

    led_heartbeat_driver #(.CLK_HZ(1000), .BLIP_MS(10), .PWM_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .mode(mode),
        .mode_active(mode_active), .beat_cnt(beat_cnt), .led_h(led_h)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: s = clock edges since reset (the free-running PWM
    // phase); patterns derived from the time of the last relevant tick.
    int s = 0, beat_m = 0, mm = 0, bcount = 0, hb_t = -1000, seg_t = 0, d0 = 0;
    bit dir_m = 1'b1;

    function automatic int br_duty(input int at);
        int st, v;
        st = (at - seg_t) / STEP;
        v  = dir_m ? d0 + st : d0 - st;
        if (v > DMAX) v = DMAX;
        if (v < 0) v = 0;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s = 0; beat_m = 0; mm = 0; bcount = 0; hb_t = -1000;
            seg_t = 0; d0 = 0; dir_m = 1'b1;
        end else begin : model_step
            int dprev;
            bit ent;
            dprev = br_duty(s);
            s = s + 1;
            ent = 1'b0;
            if (sec_tick) begin
                beat_m = (beat_m + 1) % 256;
                if (int'(mode) != mm) begin
                    mm = int'(mode);
                    ent = 1'b1;
                end
                case (mm)
                    1: bcount = ent ? 1 : bcount + 1;
                    2: hb_t = s;
                    3: begin
                        if (ent) begin d0 = 0; dir_m = 1'b1; end
                        else begin d0 = dprev; dir_m = !dir_m; end
                        seg_t = s;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        int el, d;
        if (chk_en) begin
            el = 0;
            d = s - hb_t;
            case (mm)
                1: el = bcount % 2;
                2: el = ((d >= 0 && d < BLIP) || (d >= 2*BLIP && d < 3*BLIP)) ? 1 : 0;
                3: el = ((s % 16) < br_duty(s)) ? 1 : 0;
                default: el = 0;
            endcase
            check("led_h", int'(led_h), el ^ INV);
            check("beat_cnt", int'(beat_cnt), beat_m);
            check("mode_active", int'(mode_active), mm);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        sec_tick = 1'b1;
        cyc(1);
        sec_tick = 1'b0;
    endtask

    task automatic count_on(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (led_h == ON_V) n++;
            cyc(1);
        end
    endtask

    initial begin : stim
        int cnt;
        cyc(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_led", int'(led_h), int'(OFF_V));
        check("rst_beat", int'(beat_cnt), 0);
        check("rst_mode", int'(mode_active), 0);

        repeat (3) begin pulse(); cyc(4); end
        check("off_beat3", int'(beat_cnt), 3);
        check("off_mode", int'(mode_active), 0);
        check("off_led", int'(led_h), int'(OFF_V));

        mode = 2'd1;
        cyc(70);
        pulse();
        check("blink_enter_mode", int'(mode_active), 1);
        check("blink_enter_led", int'(led_h), int'(ON_V));
        cyc(5);
        pulse();
        check("blink_toggle", int'(led_h), int'(OFF_V));
        cyc(3);
        sec_tick = 1'b1;
        cyc(256);
        sec_tick = 1'b0;
        check("beat_wrap", int'(beat_cnt), 5);
        check("blink_after_256", int'(led_h), int'(OFF_V));

        mode = 2'd2;
        cyc(10);
        pulse();
        check("hb_blip1", int'(led_h), int'(ON_V));
        cyc(14);
        check("hb_gap", int'(led_h), int'(OFF_V));
        pulse();
        check("hb_restart", int'(led_h), int'(ON_V));
        cyc(BLIP);
        check("hb_gap2", int'(led_h), int'(OFF_V));
        cyc(BLIP);
        check("hb_blip2", int'(led_h), int'(ON_V));
        cyc(BLIP);
        check("hb_idle", int'(led_h), int'(OFF_V));
        cyc(20);

        mode = 2'd1;
        pulse();
        cyc(20);
        mode = 2'd2;
        cyc(30);
        check("mid_second_mode", int'(mode_active), 1);
        check("mid_second_led", int'(led_h), int'(ON_V));
        pulse();
        check("hb_from_blip1_mode", int'(mode_active), 2);
        check("hb_from_blip1_led", int'(led_h), int'(ON_V));
        cyc(14);
        check("pre_reset_gap", int'(led_h), int'(OFF_V));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(led_h), int'(OFF_V));
        check("async_rst_beat", int'(beat_cnt), 0);
        check("async_rst_mode", int'(mode_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(25);
        check("post_reset_led", int'(led_h), int'(OFF_V));
        check("post_reset_mode", int'(mode_active), 0);

        mode = 2'd3;
        pulse();
        cyc(440);
        count_on(cnt);
        check("duty_mid", cnt, 7);
        cyc(484);
        count_on(cnt);
        check("duty_max", cnt, 15);
        cyc(43);
        pulse();
        cyc(940);
        count_on(cnt);
        check("duty_min", cnt, 0);
        cyc(43);
        pulse();
        cyc(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
